// File: rtl/regfile_sequencer_if.sv
// Handshake and register-file port bundle for regfile_sequencer.
// master = instruction source / register file side, slave = sequencer.
interface regfile_sequencer_if #(
  parameter int DATA_W = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        instr;
  logic [1:0]        rf_rs1;
  logic [1:0]        rf_rs2;
  logic [1:0]        rf_rd;
  logic              rf_reg_write;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  logic              busy;
  logic              done;
  logic              carry_flag;
  logic              zero_flag;

  modport master (
    output instr_valid, instr, rf_rd1, rf_rd2,
    input  instr_ready, rf_rs1, rf_rs2, rf_rd, rf_reg_write, rf_write_data,
           busy, done, carry_flag, zero_flag
  );

  modport slave (
    input  instr_valid, instr, rf_rd1, rf_rd2,
    output instr_ready, rf_rs1, rf_rs2, rf_rd, rf_reg_write, rf_write_data,
           busy, done, carry_flag, zero_flag
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer owning the 4-entry register file write port.
// state | meaning
// IDLE  | ready for an instruction; LDI jumps straight to WRITE
// READ  | read addresses driven, operands captured at end of cycle
// EXEC  | ALU result and next flag values registered
// WRITE | single register-file write, done pulse, flags committed
module regfile_sequencer #(
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  regfile_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;

  state_t            state_q, state_d;
  logic [7:0]        instr_q, instr_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              carry_nx_q, carry_nx_d;
  logic              zero_nx_q, zero_nx_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [1:0]        rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  assign sum_w = {1'b0, op_a_q} + {1'b0, op_b_q};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (instr_q[7:6])
      OP_ADD: begin
        alu_res   = sum_w[DATA_W-1:0];
        alu_carry = sum_w[DATA_W];
      end
      OP_SUB: begin
        alu_res   = op_a_q - op_b_q;
        alu_carry = (op_a_q < op_b_q);
      end
      OP_LDI: begin
        alu_res   = DATA_W'(instr_q[3:0]);
        alu_carry = 1'b0;
      end
      default: begin
        alu_res   = op_a_q & op_b_q;
        alu_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    carry_nx_d = carry_nx_q;
    zero_nx_d  = zero_nx_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    ready_d    = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    we_d       = 1'b0;
    rd_d       = '0;
    wdata_d    = '0;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid && ready_q) begin
          instr_d = bus.instr;
          if (bus.instr[7:6] == OP_LDI) begin
            state_d = WRITE;
            we_d    = 1'b1;
            done_d  = 1'b1;
            rd_d    = bus.instr[5:4];
            wdata_d = DATA_W'(bus.instr[3:0]);
          end else begin
            state_d = READ;
          end
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      READ: begin
        op_a_d  = bus.rf_rd1;
        op_b_d  = bus.rf_rd2;
        state_d = EXEC;
      end
      EXEC: begin
        carry_nx_d = alu_carry;
        zero_nx_d  = (alu_res == '0);
        we_d       = 1'b1;
        done_d     = 1'b1;
        rd_d       = instr_q[5:4];
        wdata_d    = alu_res;
        state_d    = WRITE;
      end
      default: begin
        // LDI never touches the flags
        if (instr_q[7:6] != OP_LDI) begin
          carry_d = carry_nx_q;
          zero_d  = zero_nx_q;
        end
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      carry_nx_q <= 1'b0;
      zero_nx_q  <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      carry_nx_q <= carry_nx_d;
      zero_nx_q  <= zero_nx_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  // Reset seen during WRITE must cancel the write landing on that same edge
  assign bus.rf_reg_write  = we_q & ~reset;
  assign bus.rf_rd         = reset ? 2'b00 : rd_q;
  assign bus.rf_write_data = reset ? '0 : wdata_q;
  assign bus.done          = done_q & ~reset;

  assign bus.rf_rs1      = (state_q == READ) ? instr_q[3:2] : 2'b00;
  assign bus.rf_rs2      = (state_q == READ) ? instr_q[1:0] : 2'b00;
  assign bus.instr_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.carry_flag  = carry_q;
  assign bus.zero_flag   = zero_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: directed test-plan steps plus random instructions
// checked against a per-instruction arithmetic model of the register file.
module tb_regfile_sequencer;
  localparam int DW   = 4;
  localparam int MAXV = 1 << DW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   mreg [4];
  int   mc = 0;
  int   mz = 0;
  logic [DW-1:0] rf [4];
  logic [7:0] rq [$];

  regfile_sequencer_if #(.DATA_W(DW)) bus();
  regfile_sequencer #(.DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  assign bus.rf_rd1 = rf[bus.rf_rs1];
  assign bus.rf_rd2 = rf[bus.rf_rs2];
  always @(posedge clk) if (bus.rf_reg_write) rf[bus.rf_rd] <= bus.rf_write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, bus.instr_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_we"}, bus.rf_reg_write, 0);
    chk({tag, "_rd"}, bus.rf_rd, 0);
    chk({tag, "_wdata"}, bus.rf_write_data, 0);
    chk({tag, "_rs"}, {bus.rf_rs1, bus.rf_rs2}, 0);
    chk({tag, "_carry"}, bus.carry_flag, mc);
    chk({tag, "_zero"}, bus.zero_flag, mz);
  endtask

  // One instruction end to end; keep holds instr_valid high with nxt queued
  task automatic run(input logic [7:0] ins, input bit keep, input logic [7:0] nxt);
    int op, rd, s1, s2, a, b, res, c, n;
    n = 0;
    while (!bus.instr_ready && n < 20) begin step(); n++; end
    chk("ready_wait", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr = ins;
    op = int'(ins[7:6]); rd = int'(ins[5:4]); s1 = int'(ins[3:2]); s2 = int'(ins[1:0]);
    a = mreg[s1]; b = mreg[s2]; c = 0;
    case (op)
      0: begin res = (a + b) % MAXV; c = ((a + b) >= MAXV) ? 1 : 0; end
      1: begin res = (a - b + MAXV) % MAXV; c = (a < b) ? 1 : 0; end
      2: res = int'(ins[3:0]);
      default: res = a & b;
    endcase
    step();
    if (keep) bus.instr = nxt;
    else begin bus.instr_valid = 1'b0; bus.instr = 8'($urandom); end
    chk("busy", bus.busy, 1);
    chk("ready_busy", bus.instr_ready, 0);
    if (op != 2) begin
      chk("read_rs1", bus.rf_rs1, s1);
      chk("read_rs2", bus.rf_rs2, s2);
      chk("read_we", bus.rf_reg_write, 0);
      chk("read_done", bus.done, 0);
      step();
      chk("exec_rs1", bus.rf_rs1, 0);
      chk("exec_we", bus.rf_reg_write, 0);
      chk("exec_done", bus.done, 0);
      chk("exec_ready", bus.instr_ready, 0);
      step();
    end
    chk("wr_done", bus.done, 1);
    chk("wr_we", bus.rf_reg_write, 1);
    chk("wr_rd", bus.rf_rd, rd);
    chk("wr_data", bus.rf_write_data, res);
    chk("wr_ready", bus.instr_ready, 0);
    step();
    mreg[rd] = res;
    if (op != 2) begin mc = c; mz = (res == 0) ? 1 : 0; end
    chk_idle("post");
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    for (int i = 0; i < 4; i++) mreg[i] = 0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk_idle("reset");

    // test-plan directed sequence
    run(8'h95, 0, 8'h00);
    run(8'h99, 0, 8'h00);
    run(8'hA8, 0, 8'h00);
    run(8'h80, 0, 8'h00);
    run(8'hB0, 0, 8'h00);
    run(8'h36, 0, 8'h00);
    chk("add_data_const", mreg[3], 1);
    chk("add_carry_const", bus.carry_flag, 1);
    run(8'h49, 0, 8'h00);
    chk("sub_data_const", mreg[0], 15);

    // reset during EXEC of an ADD
    bus.instr_valid = 1'b1;
    bus.instr = 8'h36;
    step();
    bus.instr_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("rst_exec_we", bus.rf_reg_write, 0);
    chk("rst_exec_done", bus.done, 0);
    step();
    reset = 1'b0;
    mc = 0; mz = 0;
    chk_idle("rst_exec");
    step();
    chk_idle("rst_exec2");

    run(8'h45, 0, 8'h00);
    chk("sub_zero_const", bus.zero_flag, 1);
    run(8'h9C, 0, 8'h00);
    run(8'hA6, 0, 8'h00);
    run(8'hD6, 0, 8'h00);
    chk("and_data_const", mreg[1], 4);

    // instr_valid held high with dependent instructions queued
    run(8'h83, 1, 8'h00);
    run(8'h00, 1, 8'hB7);
    run(8'hB7, 1, 8'h2C);
    run(8'h2C, 0, 8'h00);
    chk("dep_add_const", mreg[2], 13);

    // reset in WRITE of an LDI, with a handshake offered during reset
    bus.instr_valid = 1'b1;
    bus.instr = 8'hB5;
    step();
    bus.instr = 8'hBF;
    reset = 1'b1;
    #1;
    chk("rst_wr_we", bus.rf_reg_write, 0);
    chk("rst_wr_done", bus.done, 0);
    chk("rst_wr_data", bus.rf_write_data, 0);
    step();
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    mc = 0; mz = 0;
    chk_idle("rst_wr");
    chk("rst_wr_rf", rf[3], mreg[3]);
    step();
    chk_idle("rst_hs");
    chk("rst_hs_rf", rf[3], mreg[3]);

    // random instructions, random back-to-back holding
    for (int i = 0; i < 25; i++) rq.push_back(8'($urandom));
    for (int i = 0; i < 24; i++) run(rq[i], 1'($urandom), rq[i+1]);
    run(rq[24], 0, 8'h00);
    for (int i = 0; i < 4; i++) chk("final_rf", rf[i], mreg[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
